comparator_8bit: RTL and testbench

//   Unsigned magnitude comparator for two WIDTH-bit operands A and B.

---
 rtl/comparator_8bit_pkg.sv | 18 +
 rtl/comparator_8bit_slice4.sv | 33 +++
 rtl/comparator_8bit.sv | 62 ++++++
 tb/tb_comparator_8bit.sv | 103 ++++++++++
 4 files changed

// File: rtl/comparator_8bit_pkg.sv
// rtl/comparator_8bit_pkg.sv - shared slice width and result type for the magnitude comparator
package comparator_8bit_pkg;

   localparam int SLICE_W = 4;

   // Bit order matches the output triples: {lt, eq, gt}
   typedef struct packed {
      logic lt;
      logic eq;
      logic gt;
   } cmp_result_t;

   localparam cmp_result_t CMP_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};
   localparam cmp_result_t CMP_EQ   = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};
   localparam cmp_result_t CMP_LT   = '{lt: 1'b1, eq: 1'b0, gt: 1'b0};
   localparam cmp_result_t CMP_GT   = '{lt: 1'b0, eq: 1'b0, gt: 1'b1};

endpackage

// File: rtl/comparator_8bit_slice4.sv
// rtl/comparator_8bit_slice4.sv - 4-bit cascadable magnitude compare slice
module comparator_slice4
   import comparator_8bit_pkg::*;
(
   input  logic [SLICE_W-1:0] a,
   input  logic [SLICE_W-1:0] b,
   input  logic               lt_in,
   input  logic               eq_in,
   input  logic               gt_in,
   output logic               lt,
   output logic               eq,
   output logic               gt
);

   cmp_result_t res;

   // Local inequality wins; only a locally equal nibble defers to the lower slices
   always_comb begin
      res = CMP_NONE;
      if (a < b) begin
         res = CMP_LT;
      end else if (a > b) begin
         res = CMP_GT;
      end else begin
         res = '{lt: lt_in, eq: eq_in, gt: gt_in};
      end
   end

   assign lt = res.lt;
   assign eq = res.eq;
   assign gt = res.gt;

endmodule

// File: rtl/comparator_8bit.sv
// rtl/comparator_8bit.sv - unsigned WIDTH-bit comparator with combinational and registered result triples
module comparator_8bit
   import comparator_8bit_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             less,
   output logic             equal,
   output logic             More,
   output logic             AltB,
   output logic             AeqB,
   output logic             AgtB
);

   localparam int N_SLICE = WIDTH / SLICE_W;

   // Cascade node k feeds slice k; node 0 is the "all lower bits equal" seed
   logic [N_SLICE:0] lt_c;
   logic [N_SLICE:0] eq_c;
   logic [N_SLICE:0] gt_c;

   assign lt_c[0] = 1'b0;
   assign eq_c[0] = 1'b1;
   assign gt_c[0] = 1'b0;

   for (genvar k = 0; k < N_SLICE; k++) begin : g_slice
      comparator_slice4 u_slice (
         .a     (A[k*SLICE_W +: SLICE_W]),
         .b     (B[k*SLICE_W +: SLICE_W]),
         .lt_in (lt_c[k]),
         .eq_in (eq_c[k]),
         .gt_in (gt_c[k]),
         .lt    (lt_c[k+1]),
         .eq    (eq_c[k+1]),
         .gt    (gt_c[k+1])
      );
   end

   assign less  = lt_c[N_SLICE];
   assign equal = eq_c[N_SLICE];
   assign More  = gt_c[N_SLICE];

   cmp_result_t result_q;

   // All-zero after reset marks "no valid result yet"
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= CMP_NONE;
      end else begin
         result_q <= '{lt: less, eq: equal, gt: More};
      end
   end

   assign AltB = result_q.lt;
   assign AeqB = result_q.eq;
   assign AgtB = result_q.gt;

endmodule

// File: tb/tb_comparator_8bit.sv
// tb/tb_comparator_8bit.sv - self-checking bench for comparator_8bit
module tb_comparator_8bit;
   import comparator_8bit_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] A   = 8'h00;
   logic [7:0] B   = 8'h00;
   logic       less, equal, More, AltB, AeqB, AgtB;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   comparator_8bit #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .A     (A),
      .B     (B),
      .less  (less),
      .equal (equal),
      .More  (More),
      .AltB  (AltB),
      .AeqB  (AeqB),
      .AgtB  (AgtB)
   );

   function automatic cmp_result_t ref_cmp(input int unsigned a, input int unsigned b);
      cmp_result_t r;
      r.lt = (a < b);
      r.eq = (a == b);
      r.gt = (a > b);
      return r;
   endfunction

   task automatic check(input string tag, input cmp_result_t obs, input cmp_result_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // One vector per cycle: drive at negedge, check comb, check register after the edge
   task automatic apply(input logic [7:0] a_v, input logic [7:0] b_v, input logic rst_v,
                        input string tag);
      cmp_result_t exp;
      cmp_result_t exp_reg;
      @(negedge clk);
      A   = a_v;
      B   = b_v;
      rst = rst_v;
      #1;
      exp = ref_cmp(a_v, b_v);
      check({tag, " comb"}, {less, equal, More}, exp);
      @(posedge clk);
      #1;
      exp_reg = rst_v ? CMP_NONE : exp;
      check({tag, " reg"}, {AltB, AeqB, AgtB}, exp_reg);
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       rr;

      apply(8'hFF, 8'h00, 1'b1, "rst_c1");
      apply(8'hFF, 8'h00, 1'b1, "rst_c2");

      apply(8'h00, 8'h00, 1'b0, "eq_zero");
      apply(8'hFF, 8'hFF, 1'b0, "eq_ones");

      apply(8'h01, 8'h02, 1'b0, "lt_small");
      apply(8'h02, 8'h01, 1'b0, "gt_small");

      apply(8'h10, 8'h08, 1'b0, "gt_upper");
      apply(8'h80, 8'h7F, 1'b0, "gt_msb");
      apply(8'hFF, 8'h00, 1'b0, "ones_vs_zero");
      apply(8'h7F, 8'h80, 1'b0, "lt_msb");

      apply(8'h35, 8'h36, 1'b0, "lt_lower");
      apply(8'h35, 8'h36, 1'b1, "midrst");
      apply(8'h35, 8'h36, 1'b0, "post_rst");

      for (int i = 0; i < 65536; i++) begin
         ra = 8'(i >> 8);
         rb = 8'(i);
         apply(ra, rb, 1'b0, $sformatf("exh_%02h_%02h", ra, rb));
      end

      // Random operands with sporadic reset pulses
      for (int i = 0; i < 1000; i++) begin
         ra = 8'($urandom);
         rb = ($urandom_range(0, 7) == 0) ? ra : 8'($urandom);
         rr = ($urandom_range(0, 15) == 0);
         apply(ra, rb, rr, $sformatf("rnd_%02h_%02h_r%0d", ra, rb, rr));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
